// File: rtl/dual_comparator.sv
// Dual-mode (unsigned / two's-complement) magnitude comparator with registered flags and change pulse.
// Optional sticky "A > B seen" flag with synchronous clear, enabled by DUAL_CMP_STICKY_EN.
module dual_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
`ifdef DUAL_CMP_STICKY_EN
  input  logic             clr,
  output logic             agtb_seen,
`endif
  output logic             agtb,
  output logic             aeqb,
  output logic             altb,
  output logic             agtb_q,
  output logic             aeqb_q,
  output logic             altb_q,
  output logic             chg
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [2:0]  FLAGS_RST = 3'b010;

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic [2:0]       flags_q;
  logic [2:0]       flags_prev;

  // Flipping the MSB in signed mode maps two's-complement order onto unsigned order.
  assign a_key = {a[MSB] ^ mode, a[MSB-1:0]};
  assign b_key = {b[MSB] ^ mode, b[MSB-1:0]};

  assign agtb = (a_key > b_key);
  assign aeqb = (a == b);
  assign altb = (a_key < b_key);

  // flags_prev trails flags_q by one edge so chg lands the cycle after the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= FLAGS_RST;
      flags_prev <= FLAGS_RST;
      chg        <= 1'b0;
    end else begin
      flags_q    <= {agtb, aeqb, altb};
      flags_prev <= flags_q;
      chg        <= (flags_q != flags_prev);
    end
  end

  assign agtb_q = flags_q[2];
  assign aeqb_q = flags_q[1];
  assign altb_q = flags_q[0];

`ifdef DUAL_CMP_STICKY_EN
  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agtb_seen <= 1'b0;
    end else if (agtb) begin
      agtb_seen <= 1'b1;
    end else if (clr) begin
      agtb_seen <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dual_comparator.sv
// Randomized self-checking bench for dual_comparator against an integer-arithmetic reference model.
module tb_dual_comparator;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             clk_en = 1'b1;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             agtb, aeqb, altb, agtb_q, aeqb_q, altb_q, chg;
`ifdef DUAL_CMP_STICKY_EN
  logic             clr;
  logic             agtb_seen;
  logic             exp_seen;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] hist[$];

  always #5 if (clk_en) clk = ~clk;

  dual_comparator #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
`ifdef DUAL_CMP_STICKY_EN
    .clr(clr), .agtb_seen(agtb_seen),
`endif
    .agtb(agtb), .aeqb(aeqb), .altb(altb),
    .agtb_q(agtb_q), .aeqb_q(aeqb_q), .altb_q(altb_q), .chg(chg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (a=%0h b=%0h mode=%0b)", tag, got, exp, a, b, mode);
    end
  endtask

  // Reference: interpret operands as plain integers and compare.
  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic m);
    int vx, vy;
    vx = int'(x);
    vy = int'(y);
    if (m) begin
      if (vx >= 128) vx -= 256;
      if (vy >= 128) vy -= 256;
    end
    return {vx > vy, vx == vy, vx < vy};
  endfunction

  task automatic apply(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m,
                       input string tag);
    a = x; b = y; mode = m;
    #1;
    check(tag, 32'({agtb, aeqb, altb}), 32'(ref_flags(x, y, m)));
  endtask

  task automatic reset_model();
    hist = '{3'b010, 3'b010, 3'b010};
`ifdef DUAL_CMP_STICKY_EN
    exp_seen = 1'b0;
`endif
  endtask

  task automatic tick();
    logic [2:0] live;
    @(posedge clk);
    live = ref_flags(a, b, mode);
    if (rst_n) begin
      hist.push_back(live);
`ifdef DUAL_CMP_STICKY_EN
      if (live[2]) exp_seen = 1'b1;
      else if (clr) exp_seen = 1'b0;
`endif
    end
    #1;
    check("flags_q", 32'({agtb_q, aeqb_q, altb_q}), 32'(hist[$]));
    check("chg", 32'(chg), 32'(hist[$-1] != hist[$-2]));
`ifdef DUAL_CMP_STICKY_EN
    check("agtb_seen", 32'(agtb_seen), 32'(exp_seen));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; a = 8'd5; b = 8'd3; mode = 1'b0;
`ifdef DUAL_CMP_STICKY_EN
    clr = 1'b0;
`endif
    reset_model();

    // Combinational checks with the clock stopped and reset held.
    @(negedge clk);
    clk_en = 1'b0;
    apply(8'h0F, 8'hF0, 1'b0, "0F_F0_uns");
    apply(8'h0F, 8'hF0, 1'b1, "0F_F0_sgn");
    apply(8'h80, 8'h80, 1'b0, "80_80_uns");
    apply(8'h80, 8'h80, 1'b1, "80_80_sgn");
    apply(8'h7F, 8'h80, 1'b0, "7F_80_uns");
    apply(8'h7F, 8'h80, 1'b1, "7F_80_sgn");
    apply(8'hFF, 8'h00, 1'b0, "FF_00_uns");
    apply(8'hFF, 8'h00, 1'b1, "FF_00_sgn");
    check("0F_F0_sgn_agtb", 32'(ref_flags(8'h0F, 8'hF0, 1'b1) == 3'b100), 32'(agtb == 1'b0));
    clk_en = 1'b1;

    // Reset held: registered outputs at reset values.
    apply(8'd5, 8'd3, 1'b0, "5_3");
    tick();
    tick();
    check("rst_agtb_q", 32'(agtb_q), 32'd0);
    check("rst_aeqb_q", 32'(aeqb_q), 32'd1);

    // Release: agtb_q after first edge, chg one cycle later, then low.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_agtb_q", 32'(agtb_q), 32'd1);
    tick();
    check("rel_chg", 32'(chg), 32'd1);
    tick();
    check("rel_chg_low", 32'(chg), 32'd0);

`ifdef DUAL_CMP_STICKY_EN
    // Sticky: one-cycle agtb pulse, clear, and set-wins-over-clear.
    @(negedge clk); apply(8'd1, 8'd2, 1'b0, "st_lt"); clr = 1'b1; tick();
    @(negedge clk); clr = 1'b0; apply(8'd9, 8'd2, 1'b0, "st_gt"); tick();
    @(negedge clk); apply(8'd2, 8'd2, 1'b0, "st_eq"); tick(); tick();
    check("st_hold", 32'(agtb_seen), 32'd1);
    @(negedge clk); clr = 1'b1; tick();
    check("st_clr", 32'(agtb_seen), 32'd0);
    @(negedge clk); apply(8'd9, 8'd2, 1'b0, "st_gt2"); tick();
    check("st_setwins", 32'(agtb_seen), 32'd1);
    @(negedge clk); clr = 1'b0;
`endif

    // Randomized phase; repeated values are biased in to exercise chg=0.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
`ifdef DUAL_CMP_STICKY_EN
      clr = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 3) == 0) begin
        apply(a, b, mode, "rand_hold");
      end else if ($urandom_range(0, 4) == 0) begin
        apply(a, a, $urandom_range(0, 1) == 1, "rand_eq");
      end else begin
        apply(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 1) == 1, "rand");
      end
      tick();
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    apply(8'd200, 8'd1, 1'b0, "ar_gt");
    tick();
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_flags_q", 32'({agtb_q, aeqb_q, altb_q}), 32'h2);
    check("async_chg", 32'(chg), 32'd0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_comparator.md
# dual_comparator

Dual-mode magnitude comparator for WIDTH-bit operands. It compares `a` against `b` as either unsigned or two's-complement signed values, selected per comparison by `mode`. Combinational flags serve datapath logic in the same cycle. A registered copy of the flags and a change pulse are provided for control logic in the `clk` domain.

## Interface
- `WIDTH`, default 8: operand width in bits; minimum 2.
- `clk`  in  1: system clock; all registers update on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `mode`  in  1: comparison mode; 0 = unsigned, 1 = signed two's complement.
- `agtb`  out  1: combinational; 1 when A > B under the current `mode`.
- `aeqb`  out  1: combinational; 1 when A == B (bitwise; independent of `mode`).
- `altb`  out  1: combinational; 1 when A < B under the current `mode`.
- `agtb_q`, `aeqb_q`, `altb_q`  out  1 each: registered copies of the three flags.
- `chg`  out  1: one-cycle pulse when the registered flag vector changes.
- `clr`  in  1: synchronous clear of the sticky flag. Present only with `DUAL_CMP_STICKY_EN`.
- `agtb_seen`  out  1: sticky "A > B occurred" flag. Present only with `DUAL_CMP_STICKY_EN`.

## Operation
- Unsigned mode: compare the operands as integers in the range 0..2^WIDTH-1.
- Signed mode: compare the operands as integers in the range -2^(WIDTH-1)..2^(WIDTH-1)-1.
- Required implementation: invert the MSB of both operands when `mode`=1, then perform an unsigned compare. Equivalently, use a (WIDTH+1)-bit subtraction with sign-correct extension.
- Exactly one of `agtb`, `aeqb`, `altb` is 1 at all times when the inputs are known.
- `aeqb` does not depend on `mode`. `agtb` and `altb` swap for operand pairs whose MSBs differ when `mode` toggles.
- Combinational outputs do not depend on `clk` or `rst_n`. They are valid during reset.
- Registered stage: {`agtb_q`,`aeqb_q`,`altb_q`} <= {`agtb`,`aeqb`,`altb`} every rising edge.
- `chg` is registered and equals 1 for the cycle after the registered vector takes a value different from its previous value.

## Timing
- Combinational flags: zero-cycle latency, purely combinational from `a`, `b`, `mode`.
- Registered flags: 1-cycle latency.
- `chg`: asserted in the cycle after the registered flags update (2 cycles after the input change).
- Reset values: `agtb_q`=0, `aeqb_q`=1, `altb_q`=0 (equivalent to a=b=0), `chg`=0, `agtb_seen`=0.
- The first edge after reset release loads the live flags. `chg` pulses if that value differs from the reset value.
- Asserting `rst_n` mid-operation forces the reset values immediately, without waiting for a clock edge.
- `mode` changing on the same edge as `a`/`b`: treated as one new comparison; no intermediate result is registered.

## Configuration
- `DUAL_CMP_STICKY_EN` defined: adds the `clr` input and the `agtb_seen` output.
  - `agtb_seen` sets on any edge where `agtb`=1.
  - `agtb_seen` clears on an edge where `clr`=1 and `agtb`=0.
  - Set wins when `clr` and `agtb` are both 1 on the same edge.
- `DUAL_CMP_STICKY_EN` undefined: the `clr` and `agtb_seen` ports and their logic are absent. All other behaviour is identical.

## Test plan
- a=8'h0F, b=8'hF0, mode=0 -> agtb=0, altb=1 (15 < 240). Set mode=1 -> agtb=1, altb=0 (15 > -16). Same result with the clock stopped.
- a=b=8'h80, both modes -> aeqb=1, agtb=0, altb=0. Check a=8'h7F vs b=8'h80: mode=0 -> altb=1; mode=1 -> agtb=1.
- Extremes: a=8'hFF, b=8'h00 -> mode=0 gives agtb=1; mode=1 gives altb=1 (-1 < 0).
- Reset: hold rst_n=0 with a=5, b=3 -> registered outputs 0/1/0 and chg=0. Release rst_n -> agtb_q=1 after the first edge, chg=1 on the next cycle, then chg returns to 0.
- Asynchronous reset: drop rst_n between clock edges -> registered outputs return to reset values immediately.
- With DUAL_CMP_STICKY_EN: pulse agtb for one cycle -> agtb_seen stays 1. Apply clr with agtb=0 -> agtb_seen=0. Apply clr with agtb=1 -> agtb_seen stays 1.
